// File: rtl/wb_rr_arbiter_if.sv
// Arbiter-side Wishbone signal bundle: per-master cycle requests, muxed strobe and
// OR'ed slave terminations in; grant index, qualified cycle and watchdog error out.
interface wb_rr_arbiter_if #(
  parameter int MASTER_COUNT = 2,
  parameter int GNT_WIDTH    = $clog2(MASTER_COUNT)
);
  logic [MASTER_COUNT-1:0] cyc_i;
  logic                    stb_i;
  logic                    ack_i;
  logic                    err_i;
  logic                    rty_i;
  logic [GNT_WIDTH-1:0]    gnt_o;
  logic                    cyc_o;
  logic                    err_o;

  // Interconnect side: raises requests, consumes grant and qualified cycle.
  modport master (
    output cyc_i, stb_i, ack_i, err_i, rty_i,
    input  gnt_o, cyc_o, err_o
  );

  // Arbiter side.
  modport slave (
    input  cyc_i, stb_i, ack_i, err_i, rty_i,
    output gnt_o, cyc_o, err_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter with optional stalled-cycle watchdog.
// Define WB_ARB_TIMEOUT_EN to build the watchdog counter, ABORT state and err_o.
module wb_rr_arbiter #(
  parameter int MASTER_COUNT = 2,
  parameter int GNT_WIDTH    = $clog2(MASTER_COUNT),
  parameter int TIMEOUT      = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  wb_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
`ifdef WB_ARB_TIMEOUT_EN
    , ABORT = 2'd2
`endif
  } state_t;

  state_t               state_reg, state_next;
  logic [GNT_WIDTH-1:0] gnt_reg, gnt_next;
  logic [GNT_WIDTH-1:0] ptr_reg, ptr_next;
  logic                 cyc_out;
  logic                 err_out;

  logic [GNT_WIDTH-1:0] rot_idx [MASTER_COUNT];
  logic [MASTER_COUNT-1:0] rot_req;
  logic [GNT_WIDTH-1:0] winner;
  logic [GNT_WIDTH-1:0] winner_inc;
  logic                 any_req;
  logic                 granted_req;

  // Requests rotated so offset 0 is the master at the priority pointer.
  for (genvar gi = 0; gi < MASTER_COUNT; gi++) begin : g_rot
    logic [GNT_WIDTH:0] sum;
    assign sum = {1'b0, ptr_reg} + (GNT_WIDTH+1)'(gi);
    assign rot_idx[gi] = (sum >= (GNT_WIDTH+1)'(MASTER_COUNT))
                       ? GNT_WIDTH'(sum - (GNT_WIDTH+1)'(MASTER_COUNT))
                       : sum[GNT_WIDTH-1:0];
    assign rot_req[gi] = bus.cyc_i[rot_idx[gi]];
  end

  // Descending scan so the smallest requesting offset is written last.
  always_comb begin
    winner = rot_idx[0];
    for (int i = MASTER_COUNT - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        winner = rot_idx[i];
      end
    end
  end

  assign winner_inc  = (winner == GNT_WIDTH'(MASTER_COUNT - 1)) ? '0 : winner + GNT_WIDTH'(1);
  assign any_req     = |bus.cyc_i;
  assign granted_req = bus.cyc_i[gnt_reg];

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             stalled;
  assign stalled = bus.stb_i & ~(bus.ack_i | bus.err_i | bus.rty_i);
`else
  logic unused_wd;
  assign unused_wd = ^{bus.stb_i, bus.ack_i, bus.err_i, bus.rty_i, (TIMEOUT != 0)};
`endif

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    ptr_next   = ptr_reg;
    cyc_out    = 1'b0;
    err_out    = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_next   = '0;
`endif
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          gnt_next   = winner;
          ptr_next   = winner_inc;
          state_next = GRANT;
        end
      end
      GRANT: begin
        cyc_out = granted_req;
        if (!granted_req) begin
          // Release: hand over at this edge, or park the last grant.
          if (any_req) begin
            gnt_next = winner;
            ptr_next = winner_inc;
          end else begin
            state_next = IDLE;
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (stalled) begin
          if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            state_next = ABORT;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        err_out = 1'b1;
        if (granted_req) begin
          state_next = GRANT;
        end else if (any_req) begin
          gnt_next   = winner;
          ptr_next   = winner_inc;
          state_next = GRANT;
        end else begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      ptr_reg   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      ptr_reg   <= ptr_next;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

  assign bus.gnt_o = gnt_reg;
  assign bus.cyc_o = cyc_out;
  assign bus.err_o = err_out;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter (MASTER_COUNT=2, TIMEOUT=4); watchdog vectors
// run when WB_ARB_TIMEOUT_EN is defined, the no-watchdog stall vectors otherwise.
module tb_wb_rr_arbiter;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.MASTER_COUNT(2), .GNT_WIDTH(1)) bus ();

  wb_rr_arbiter #(
    .MASTER_COUNT(2),
    .GNT_WIDTH   (1),
    .TIMEOUT     (4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  typedef struct {
    int   id;
    logic g;
    logic c;
    logic e;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Drive one cycle of inputs just after the edge and queue the outputs expected in that cycle.
  task automatic step(input logic [1:0] c, input logic s, input logic a, input logic e,
                      input logic g_exp, input logic c_exp, input logic e_exp);
    @(posedge clk);
    #1;
    bus.cyc_i = c;
    bus.stb_i = s;
    bus.ack_i = a;
    bus.err_i = e;
    bus.rty_i = 1'b0;
    sb.push_back('{txn, g_exp, c_exp, e_exp});
    txn++;
  endtask

  task automatic check_now(input string name, input logic g_exp, input logic c_exp, input logic e_exp);
    checks++;
    if ({bus.gnt_o, bus.cyc_o, bus.err_o} !== {g_exp, c_exp, e_exp}) begin
      errors++;
      $display("FAIL %s: gnt/cyc/err got %b/%b/%b expected %b/%b/%b",
               name, bus.gnt_o, bus.cyc_o, bus.err_o, g_exp, c_exp, e_exp);
    end else begin
      $display("%s ok gnt=%0d cyc=%0d err=%0d", name, bus.gnt_o, bus.cyc_o, bus.err_o);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_x = sb.pop_front();
      checks++;
      if ({bus.gnt_o, bus.cyc_o, bus.err_o} !== {mon_x.g, mon_x.c, mon_x.e}) begin
        errors++;
        $display("FAIL txn %0d: gnt/cyc/err got %b/%b/%b expected %b/%b/%b",
                 mon_x.id, bus.gnt_o, bus.cyc_o, bus.err_o, mon_x.g, mon_x.c, mon_x.e);
      end else begin
        $display("txn %0d ok gnt=%0d cyc=%0d err=%0d", mon_x.id, bus.gnt_o, bus.cyc_o, bus.err_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cyc_i = 2'b00;
    bus.stb_i = 1'b0;
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    bus.rty_i = 1'b0;
    @(posedge clk);
    #1;
    check_now("reset_state", 1'b0, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b1;

    // Basic grant, handover at release, parking, wrap of the pointer.
    step(2'b11, 0, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0, 1, 0);
    step(2'b11, 0, 0, 0, 0, 1, 0);
    step(2'b10, 0, 0, 0, 0, 0, 0);
    step(2'b10, 0, 0, 0, 1, 1, 0);
    step(2'b00, 0, 0, 0, 1, 0, 0);
    step(2'b00, 0, 0, 0, 1, 0, 0);
    step(2'b10, 0, 0, 0, 1, 0, 0);
    step(2'b10, 0, 0, 0, 1, 1, 0);
    step(2'b11, 0, 0, 0, 1, 1, 0);
    step(2'b01, 0, 0, 0, 1, 0, 0);
    step(2'b01, 0, 0, 0, 0, 1, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0);

    // Both masters hold, drop one cycle and re-raise: grants alternate.
    step(2'b11, 0, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 1, 1, 0);
    step(2'b11, 0, 0, 0, 1, 1, 0);
    step(2'b01, 0, 0, 0, 1, 0, 0);
    step(2'b11, 0, 0, 0, 0, 1, 0);
    step(2'b11, 0, 0, 0, 0, 1, 0);
    step(2'b10, 0, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 1, 1, 0);
    step(2'b11, 0, 0, 0, 1, 1, 0);
    step(2'b01, 0, 0, 0, 1, 0, 0);
    step(2'b11, 0, 0, 0, 0, 1, 0);
    step(2'b11, 0, 0, 0, 0, 1, 0);
    step(2'b10, 0, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 1, 1, 0);
    step(2'b01, 0, 0, 0, 1, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0);

`ifdef WB_ARB_TIMEOUT_EN
    // Four stalled cycles, one-cycle ABORT, then the same grant resumes.
    step(2'b01, 1, 0, 0, 0, 0, 0);
    repeat (4) step(2'b01, 1, 0, 0, 0, 1, 0);
    step(2'b01, 1, 0, 0, 0, 0, 1);
    step(2'b01, 0, 0, 0, 0, 1, 0);
    // Ack on the fourth stalled cycle wins; counter restarts from zero.
    repeat (3) step(2'b01, 1, 0, 0, 0, 1, 0);
    step(2'b01, 1, 1, 0, 0, 1, 0);
    repeat (4) step(2'b01, 1, 0, 0, 0, 1, 0);
    step(2'b00, 0, 1, 0, 0, 0, 1);
    step(2'b00, 0, 0, 0, 0, 0, 0);
    // Granted master drops cyc while stalled: no error.
    step(2'b01, 1, 0, 0, 0, 0, 0);
    repeat (2) step(2'b01, 1, 0, 0, 0, 1, 0);
    step(2'b00, 1, 0, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0);
`else
    // Without the watchdog a stalled cycle keeps its grant.
    step(2'b01, 1, 0, 0, 0, 0, 0);
    repeat (20) step(2'b01, 1, 0, 0, 0, 1, 0);
    step(2'b00, 1, 0, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0);
`endif

    // Grant master 1, then reset between edges.
    step(2'b10, 0, 0, 0, 0, 0, 0);
    step(2'b10, 1, 0, 0, 1, 1, 0);
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    check_now("async_reset", 1'b0, 1'b0, 1'b0);
    bus.cyc_i = 2'b00;
    bus.stb_i = 1'b0;
    @(posedge clk);
    #1;
    check_now("held_reset", 1'b0, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b1;
    // Pointer back at 0: master 0 wins a simultaneous request.
    step(2'b00, 0, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0, 1, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
